// File: rtl/icache_fetch_unit_pkg.sv
// Shared types and sizing for the direct-mapped instruction cache.
// Frame layout, FSM states and address-split helpers live here.
package icache_fetch_unit_pkg;

  localparam int WORD_W       = 32;
  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = WORD_W - ICACHE_IDX_W - 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_MISS = 1'b1
  } icache_state_t;

  function automatic logic [ICACHE_IDX_W-1:0] addr_idx(input word_t a);
    return a[ICACHE_IDX_W+1:2];
  endfunction

  function automatic logic [ICACHE_TAG_W-1:0] addr_tag(input word_t a);
    return a[WORD_W-1:ICACHE_IDX_W+2];
  endfunction

endpackage

// File: rtl/icache_fetch_unit_frame_array.sv
// Frame store for the instruction cache: combinational read, synchronous write,
// and a synchronous clear-all that takes priority over a concurrent write.
module icache_frame_array
  import icache_fetch_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    clr_i,
  input  logic                    we_i,
  input  logic [ICACHE_IDX_W-1:0] widx_i,
  input  icache_frame_t           wframe_i,
  input  logic [ICACHE_IDX_W-1:0] ridx_i,
  output icache_frame_t           rframe_o
);

  icache_frame_t frames_q [ICACHE_SETS];

  // Frame storage; only the valid bits are cleared, tag/data are don't-care when invalid.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < ICACHE_SETS; i++) begin
        frames_q[i].valid <= 1'b0;
      end
    end else if (we_i) begin
      frames_q[widx_i] <= wframe_i;
    end else begin
      frames_q[widx_i] <= frames_q[widx_i];
    end
  end

  assign rframe_o = frames_q[ridx_i];

endmodule

// File: rtl/icache_fetch_unit.sv
// Direct-mapped instruction cache between IF stage and memory controller.
// Hits return data in the same cycle; misses fetch one word and forward it on fill.
module icache_fetch_unit
  import icache_fetch_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  input  logic        flush
);

  icache_state_t state_q, state_d;
  word_t         miss_addr_q, miss_addr_d;
  icache_frame_t rframe_s, wframe_s;
  logic          we_s;
  logic          hit_s;
  logic          unused_s;

  assign unused_s = ^imemaddr[1:0];

  icache_frame_array u_frames (
    .clk      (CLK),
    .clr_i    (RST | flush),
    .we_i     (we_s),
    .widx_i   (addr_idx(miss_addr_q)),
    .wframe_i (wframe_s),
    .ridx_i   (addr_idx(imemaddr)),
    .rframe_o (rframe_s)
  );

  assign wframe_s = '{valid: 1'b1, tag: addr_tag(miss_addr_q), data: iload};
  assign hit_s    = imemREN & rframe_s.valid & (rframe_s.tag == addr_tag(imemaddr));

  // FSM state and latched miss address.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IC_IDLE;
      miss_addr_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  // Next-state, hit/forward and memory request logic.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    ihit        = 1'b0;
    imemload    = 32'h0000_0000;
    iREN        = 1'b0;
    iaddr       = 32'h0000_0000;
    we_s        = 1'b0;
    case (state_q)
      IC_IDLE: begin
        if (RST || flush) begin
          state_d = IC_IDLE;
        end else if (hit_s) begin
          ihit     = 1'b1;
          imemload = rframe_s.data;
        end else if (imemREN) begin
          miss_addr_d = {imemaddr[31:2], 2'b00};
          state_d     = IC_MISS;
        end else begin
          state_d = IC_IDLE;
        end
      end
      IC_MISS: begin
        iREN  = 1'b1;
        iaddr = miss_addr_q;
        if (!iwait) begin
          state_d = IC_IDLE;
          // A flush racing the fill must not leave a stale frame valid.
          we_s    = ~flush;
          if (!RST && !flush && imemREN && (imemaddr[31:2] == miss_addr_q[31:2])) begin
            ihit     = 1'b1;
            imemload = iload;
          end else begin
            ihit = 1'b0;
          end
        end else begin
          state_d = IC_MISS;
        end
      end
      default: begin
        state_d = IC_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_fetch_unit.sv
// Directed self-checking bench for icache_fetch_unit.
module tb_icache_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = 32'h0;
  logic        flush = 1'b0;

  int total = 0;
  int bad = 0;

  icache_fetch_unit dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .flush    (flush)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle of inputs at the falling edge, settle before the rising edge.
  task automatic drive(input logic ren, input logic [31:0] addr, input logic wt,
                       input logic [31:0] ld, input logic fl);
    @(negedge CLK);
    imemREN  = ren;
    imemaddr = addr;
    iwait    = wt;
    iload    = ld;
    flush    = fl;
    #2;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    total++; if (ihit !== 1'b0) begin bad++; $display("FAIL reset_ihit got=%b exp=0", ihit); end
    total++; if (imemload !== 32'h0) begin bad++; $display("FAIL reset_imemload got=%h exp=0", imemload); end
    total++; if (iREN !== 1'b0) begin bad++; $display("FAIL reset_iREN got=%b exp=0", iREN); end
    total++; if (iaddr !== 32'h0) begin bad++; $display("FAIL reset_iaddr got=%h exp=0", iaddr); end
  endtask

  task automatic test_first_miss();
    drive(1'b1, 32'h0, 1'b1, 32'h0, 1'b0);
    total++; if (ihit !== 1'b0 || iREN !== 1'b0) begin bad++; $display("FAIL miss_detect ihit=%b iREN=%b exp=0/0", ihit, iREN); end
    for (int c = 1; c <= 3; c++) begin
      drive(1'b1, 32'h0, 1'b1, 32'h0, 1'b0);
      total++; if (iREN !== 1'b1 || iaddr !== 32'h0 || ihit !== 1'b0) begin
        bad++; $display("FAIL miss_wait c=%0d iREN=%b iaddr=%h ihit=%b exp=1/0/0", c, iREN, iaddr, ihit);
      end
    end
    drive(1'b1, 32'h0, 1'b0, 32'h2001_0005, 1'b0);
    total++; if (iREN !== 1'b1 || ihit !== 1'b1 || imemload !== 32'h2001_0005) begin
      bad++; $display("FAIL miss_fill iREN=%b ihit=%b imemload=%h exp=1/1/20010005", iREN, ihit, imemload);
    end
    drive(1'b1, 32'h0, 1'b1, 32'h0, 1'b0);
    total++; if (iREN !== 1'b0 || ihit !== 1'b1 || imemload !== 32'h2001_0005) begin
      bad++; $display("FAIL after_fill_hit iREN=%b ihit=%b imemload=%h exp=0/1/20010005", iREN, ihit, imemload);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    int misses;
    misses = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      a = 32'(i) * 32'd4;
      drive(1'b1, a, 1'b1, 32'h0, 1'b0);
      if (ihit === 1'b0) misses++;
      drive(1'b1, a, 1'b0, 32'hC0DE_0000 | a, 1'b0);
      total++; if (ihit !== 1'b1 || imemload !== (32'hC0DE_0000 | a)) begin
        bad++; $display("FAIL seq_fill a=%h ihit=%b imemload=%h exp=1/%h", a, ihit, imemload, 32'hC0DE_0000 | a);
      end
    end
    total++; if (misses != 16) begin bad++; $display("FAIL seq_miss_count got=%0d exp=16", misses); end
    for (int i = 0; i < 16; i++) begin
      a = 32'(i) * 32'd4;
      drive(1'b1, a, 1'b1, 32'h0, 1'b0);
      total++; if (ihit !== 1'b1 || iREN !== 1'b0 || imemload !== (32'hC0DE_0000 | a)) begin
        bad++; $display("FAIL seq_hit a=%h ihit=%b iREN=%b imemload=%h", a, ihit, iREN, imemload);
      end
    end
  endtask

  task automatic test_conflict();
    drive(1'b1, 32'h40, 1'b1, 32'h0, 1'b0);
    total++; if (ihit !== 1'b0) begin bad++; $display("FAIL conflict_miss ihit=%b exp=0", ihit); end
    drive(1'b1, 32'h40, 1'b0, 32'h4040_4040, 1'b0);
    total++; if (ihit !== 1'b1 || iaddr !== 32'h40 || imemload !== 32'h4040_4040) begin
      bad++; $display("FAIL conflict_fill ihit=%b iaddr=%h imemload=%h", ihit, iaddr, imemload);
    end
    drive(1'b1, 32'h0, 1'b1, 32'h0, 1'b0);
    total++; if (ihit !== 1'b0) begin bad++; $display("FAIL conflict_evict ihit=%b exp=0", ihit); end
    drive(1'b1, 32'h0, 1'b0, 32'hC0DE_0000, 1'b0);
    total++; if (ihit !== 1'b1 || iaddr !== 32'h0) begin bad++; $display("FAIL conflict_refill ihit=%b iaddr=%h", ihit, iaddr); end
  endtask

  task automatic test_redirect();
    do_reset();
    drive(1'b1, 32'h10, 1'b1, 32'h0, 1'b0);
    drive(1'b1, 32'h10, 1'b1, 32'h0, 1'b0);
    drive(1'b1, 32'h100, 1'b1, 32'h0, 1'b0);
    total++; if (iaddr !== 32'h10 || iREN !== 1'b1) begin bad++; $display("FAIL redir_hold iaddr=%h iREN=%b exp=10/1", iaddr, iREN); end
    drive(1'b1, 32'h100, 1'b0, 32'h1111_0010, 1'b0);
    total++; if (ihit !== 1'b0 || imemload !== 32'h0) begin bad++; $display("FAIL redir_fill ihit=%b imemload=%h exp=0/0", ihit, imemload); end
    drive(1'b1, 32'h100, 1'b1, 32'h0, 1'b0);
    total++; if (ihit !== 1'b0 || iREN !== 1'b0) begin bad++; $display("FAIL redir_detect ihit=%b iREN=%b exp=0/0", ihit, iREN); end
    drive(1'b1, 32'h100, 1'b0, 32'h0100_AAAA, 1'b0);
    total++; if (iaddr !== 32'h100 || ihit !== 1'b1 || imemload !== 32'h0100_AAAA) begin
      bad++; $display("FAIL redir_new_fill iaddr=%h ihit=%b imemload=%h", iaddr, ihit, imemload);
    end
    drive(1'b1, 32'h10, 1'b1, 32'h0, 1'b0);
    total++; if (ihit !== 1'b1 || imemload !== 32'h1111_0010) begin
      bad++; $display("FAIL redir_frame4 ihit=%b imemload=%h exp=1/11110010", ihit, imemload);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h8, 1'b1, 32'h0, 1'b0);
    drive(1'b1, 32'h8, 1'b0, 32'h0800_0008, 1'b0);
    drive(1'b1, 32'h8, 1'b1, 32'h0, 1'b0);
    total++; if (ihit !== 1'b1) begin bad++; $display("FAIL flush_pre_hit ihit=%b exp=1", ihit); end
    drive(1'b1, 32'h8, 1'b1, 32'h0, 1'b1);
    total++; if (ihit !== 1'b0) begin bad++; $display("FAIL flush_cycle ihit=%b exp=0", ihit); end
    drive(1'b1, 32'h8, 1'b1, 32'h0, 1'b0);
    total++; if (ihit !== 1'b0) begin bad++; $display("FAIL flush_after ihit=%b exp=0", ihit); end
    drive(1'b1, 32'h8, 1'b0, 32'h0BAD_0008, 1'b1);
    total++; if (ihit !== 1'b0 || iREN !== 1'b1) begin bad++; $display("FAIL flush_fill ihit=%b iREN=%b exp=0/1", ihit, iREN); end
    drive(1'b1, 32'h8, 1'b1, 32'h0, 1'b0);
    total++; if (ihit !== 1'b0 || iREN !== 1'b0) begin bad++; $display("FAIL flush_no_write ihit=%b iREN=%b exp=0/0", ihit, iREN); end
    drive(1'b1, 32'h8, 0, 32'h0800_0008, 1'b0);
    drive(1'b1, 32'h8, 1'b1, 32'h0, 1'b0);
    total++; if (ihit !== 1'b1 || imemload !== 32'h0800_0008) begin bad++; $display("FAIL flush_refill ihit=%b imemload=%h", ihit, imemload); end
  endtask

  task automatic test_ren_low();
    drive(1'b0, 32'h8, 1'b1, 32'h0, 1'b0);
    total++; if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0) begin
      bad++; $display("FAIL ren_low ihit=%b imemload=%h iREN=%b exp=0/0/0", ihit, imemload, iREN);
    end
  endtask

  task automatic test_rst_mid_miss();
    drive(1'b1, 32'h20, 1'b1, 32'h0, 1'b0);
    drive(1'b1, 32'h20, 1'b1, 32'h0, 1'b0);
    total++; if (iREN !== 1'b1 || iaddr !== 32'h20) begin bad++; $display("FAIL rst_pre_miss iREN=%b iaddr=%h exp=1/20", iREN, iaddr); end
    RST = 1'b1;
    drive(1'b0, 32'h20, 1'b0, 32'h1234_5678, 1'b0);
    RST = 1'b0;
    drive(1'b0, 32'h20, 1'b1, 32'h0, 1'b0);
    total++; if (iREN !== 1'b0 || iaddr !== 32'h0) begin bad++; $display("FAIL rst_iREN_drop iREN=%b iaddr=%h exp=0/0", iREN, iaddr); end
    drive(1'b1, 32'h8, 1'b1, 32'h0, 1'b0);
    total++; if (ihit !== 1'b0) begin bad++; $display("FAIL rst_invalid_8 ihit=%b exp=0", ihit); end
    do_reset();
    drive(1'b1, 32'h20, 1'b1, 32'h0, 1'b0);
    total++; if (ihit !== 1'b0) begin bad++; $display("FAIL rst_invalid_20 ihit=%b exp=0", ihit); end
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_sequential();
    test_conflict();
    test_redirect();
    test_flush();
    test_ren_low();
    test_rst_mid_miss();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
